// File: rtl/alu_seq.sv
// Handshaked, registered ALU with an iterative shift-add multiplier; 1-cycle ops, WIDTH-cycle multiply.
// Optional status flags (zero/carry/ovf) are built when ALU_SEQ_FLAGS_EN is defined.
module alu_seq #(
  parameter int WIDTH = 20,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             busy
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             zero,
  output logic             carry,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t           state, state_d;
  logic             load_alu, load_mul, start_mul;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] acc, mcand, mplier, acc_nxt;
  logic [SHW-1:0]   cnt;

  always_comb begin
    res = '0;
    case (sel)
      3'b000: res = a;
      3'b001: res = a + b;
      3'b010: res = a - b;
      3'b011: res = a & b;
      3'b100: res = a | b;
      3'b101: res = a ^ b;
      3'b110: res = (b >= WIDTH'(WIDTH)) ? '0 : (a << b[SHW-1:0]);
      default: res = '0;
    endcase
  end

  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
  assign out_valid = (state == HOLD);
  assign busy      = (state == BUSY);

  always_comb begin
    state_d   = state;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    start_mul = 1'b0;
    in_ready  = (state == IDLE) || (state == HOLD && out_ready);
    case (state)
      IDLE, HOLD: begin
        if (in_valid && in_ready) begin
          if (sel == 3'b111) begin
            state_d   = BUSY;
            start_mul = 1'b1;
          end else begin
            state_d  = HOLD;
            load_alu = 1'b1;
          end
        end else if (state == HOLD && out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // Last iteration folds its partial product straight into c.
        if (cnt == SHW'(WIDTH - 1)) begin
          state_d  = HOLD;
          load_mul = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c      <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      if (load_alu)      c <= res;
      else if (load_mul) c <= acc_nxt;
      if (start_mul) begin
        acc    <= '0;
        mcand  <= a;
        mplier <= b;
        cnt    <= '0;
      end else if (state == BUSY) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [WIDTH:0] sum_x, dif_x;
  logic           rcy, rov;

  assign sum_x = {1'b0, a} + {1'b0, b};
  assign dif_x = {1'b0, a} - {1'b0, b};

  always_comb begin
    rcy = 1'b0;
    rov = 1'b0;
    if (sel == 3'b001) begin
      rcy = sum_x[WIDTH];
      rov = (a[WIDTH-1] == b[WIDTH-1]) && (sum_x[WIDTH-1] != a[WIDTH-1]);
    end else if (sel == 3'b010) begin
      rcy = dif_x[WIDTH];
      rov = (a[WIDTH-1] != b[WIDTH-1]) && (dif_x[WIDTH-1] != a[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero  <= 1'b0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (load_alu) begin
      zero  <= (res == '0);
      carry <= rcy;
      ovf   <= rov;
    end else if (load_mul) begin
      zero  <= (acc_nxt == '0);
      carry <= 1'b0;
      ovf   <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq; flag checks are compiled in with ALU_SEQ_FLAGS_EN.
module tb_alu_seq;
  localparam int W = 20;

  logic         clk, rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] a, b, c;
  logic [2:0]   sel;
`ifdef ALU_SEQ_FLAGS_EN
  logic         zero, carry, ovf;
`endif

  int checks   = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .busy(busy)
`ifdef ALU_SEQ_FLAGS_EN
    , .zero(zero), .carry(carry), .ovf(ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [2:0] vs);
    a = va; b = vb; sel = vs; in_valid = 1'b1;
  endtask

  initial begin
    logic seen_valid;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sel = '0;
    tick(); tick();
    chk("rst_c", 32'(c), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;
    tick();

    // add, one-cycle latency, then drain to idle
    drive(20'd8, 20'd4, 3'b001);
    tick(); in_valid = 1'b0;
    chk("add_valid", 32'(out_valid), 32'h1);
    chk("add_c", 32'(c), 32'd12);
    tick();
    chk("add_drain", 32'(out_valid), 32'h0);

    // multiply 12*3: busy for 20 cycles, result on edge 21
    drive(20'd12, 20'd3, 3'b111);
    tick(); in_valid = 1'b0; a = 20'd99; b = 20'd99;
    for (int i = 1; i <= 20; i++) begin
      chk($sformatf("mul_busy_%0d", i), {29'b0, busy, in_ready, out_valid}, 32'b100);
      if (i < 20) tick();
    end
    tick();
    chk("mul_valid", 32'(out_valid), 32'h1);
    chk("mul_busy_end", 32'(busy), 32'h0);
    chk("mul_c", 32'(c), 32'd36);
    tick();

    // subtract with borrow, then back-to-back subtract to zero
    drive(20'd4, 20'd8, 3'b010);
    tick();
    chk("sub_c", 32'(c), 32'hFFFFC);
`ifdef ALU_SEQ_FLAGS_EN
    chk("sub_carry", 32'(carry), 32'h1);
    chk("sub_zero", 32'(zero), 32'h0);
    chk("sub_ovf", 32'(ovf), 32'h0);
`endif
    drive(20'd5, 20'd5, 3'b010);
    tick();
    chk("sub0_valid", 32'(out_valid), 32'h1);
    chk("sub0_c", 32'(c), 32'h0);
`ifdef ALU_SEQ_FLAGS_EN
    chk("sub0_zero", 32'(zero), 32'h1);
    chk("sub0_carry", 32'(carry), 32'h0);
`endif
    drive(20'hFFFFF, 20'h1, 3'b001);
    tick();
    chk("addwrap_c", 32'(c), 32'h0);
`ifdef ALU_SEQ_FLAGS_EN
    chk("addwrap_carry", 32'(carry), 32'h1);
    chk("addwrap_ovf", 32'(ovf), 32'h0);
`endif
    drive(20'h7FFFF, 20'h1, 3'b001);
    tick();
    chk("addovf_c", 32'(c), 32'h80000);
`ifdef ALU_SEQ_FLAGS_EN
    chk("addovf_ovf", 32'(ovf), 32'h1);
    chk("addovf_carry", 32'(carry), 32'h0);
`endif
    drive(20'hF0F0F, 20'h0FF00, 3'b011);
    tick();
    chk("and_c", 32'(c), 32'h00F00);
    drive(20'hF0F0F, 20'h0FF00, 3'b100);
    tick();
    chk("or_c", 32'(c), 32'hFFF0F);
    in_valid = 1'b0;
    tick();

    // back-pressure: xor result held while out_ready low
    out_ready = 1'b0;
    drive(20'h1C, 20'h48, 3'b101);
    tick();
    drive(20'd7, 20'd0, 3'b000);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("bp_c_%0d", i), 32'(c), 32'h54);
      chk($sformatf("bp_hs_%0d", i), {30'b0, out_valid, in_ready}, 32'b10);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_release", 32'(in_ready), 32'h1);
    tick();
    chk("bp_next_valid", 32'(out_valid), 32'h1);
    chk("bp_next_c", 32'(c), 32'd7);

    // shifter edge cases
    drive(20'h1C, 20'd2, 3'b110);
    tick();
    chk("shl2_c", 32'(c), 32'h70);
    drive(20'h1D, 20'd19, 3'b110);
    tick();
    chk("shl19_c", 32'(c), 32'h80000);
    drive(20'h1C, 20'd20, 3'b110);
    tick();
    chk("shl20_c", 32'(c), 32'h0);
    drive(20'h1C, 20'hFFFFF, 3'b110);
    tick();
    chk("shlbig_c", 32'(c), 32'h0);

    // multiply straight from HOLD drops out_valid; wraps modulo 2^20
    drive(20'hFFFFF, 20'hFFFFF, 3'b111);
    tick(); in_valid = 1'b0;
    chk("mulwrap_drop", 32'(out_valid), 32'h0);
    for (int i = 0; i < 20; i++) tick();
    chk("mulwrap_valid", 32'(out_valid), 32'h1);
    chk("mulwrap_c", 32'(c), 32'h1);
`ifdef ALU_SEQ_FLAGS_EN
    chk("mulwrap_zero", 32'(zero), 32'h0);
`endif
    tick();

    // reset in the middle of a multiply
    drive(20'd12, 20'd3, 3'b111);
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("abort_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_c", 32'(c), 32'h0);
    chk("abort_hs", {30'b0, out_valid, busy}, 32'b00);
    tick();
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    chk("abort_no_stale", 32'(seen_valid), 32'h0);
    drive(20'd100, 20'd23, 3'b001);
    tick(); in_valid = 1'b0;
    chk("post_abort_valid", 32'(out_valid), 32'h1);
    chk("post_abort_c", 32'(c), 32'd123);
    tick();
    chk("post_abort_idle", 32'(out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's combinational 20-bit ALU.
- Registers every result and holds it under output back-pressure.
- Adds an iterative shift-add multiplier; single-cycle ops complete in 1 cycle, multiply takes WIDTH cycles.
- Sits between the operand-fetch stage and the writeback stage of the datapath, using valid/ready on both sides.

Parameters:
- WIDTH, 20, operand and result width in bits (must be >= 4).
- SHW, $clog2(WIDTH), width of the shift-amount field (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and sel are valid this cycle.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- sel  input  3  operation select (encoding below).
- out_valid  output  1  c holds a completed result.
- out_ready  input  1  downstream accepts c this cycle.
- c  output  WIDTH  registered result.
- busy  output  1  high while a multiply is iterating.

Behaviour:
- Reset (async, rst=1): state=IDLE, c=0, out_valid=0, busy=0. Multiplier accumulator, multiplicand and counter all clear.
- Reset asserted mid-multiply aborts the operation; no result is ever presented for it.
- sel encoding, all results modulo 2^WIDTH:
  - 000 pass a
  - 001 a+b
  - 010 a-b
  - 011 a&b
  - 100 a|b
  - 101 a^b
  - 110 a<<b; result is 0 when b >= WIDTH
  - 111 a*b, low WIDTH bits, unsigned
- Accept: an operation is accepted on a rising edge where in_valid && in_ready. a, b and sel are captured on that edge; later changes on the inputs have no effect.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This allows back-to-back acceptance on the same edge the held result drains.
- FSM:
  - IDLE: on accept with sel!=111, go to HOLD, load c, out_valid=1 next cycle (latency 1). On accept with sel==111, go to BUSY, load multiplier, counter=0.
  - BUSY: busy=1, in_ready=0. Each cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator; then shift the multiplicand left and the multiplier right; counter++. After exactly WIDTH cycles, load c=accumulator and go to HOLD. Multiply latency is WIDTH+1 edges from accept to out_valid=1.
  - HOLD: out_valid=1, c stable. If out_ready && in_valid, start the new operation (same rules as IDLE) and drop out_valid for a multiply, or keep out_valid high with the new c for a 1-cycle op. If out_ready && !in_valid, go to IDLE and clear out_valid. If !out_ready, stay and hold c.
- c changes only on a HOLD load. It is never updated while out_valid=1 && !out_ready.
- in_valid while in_ready=0 is ignored; upstream must keep it asserted.

Optional Feature:
- Macro: ALU_SEQ_FLAGS_EN.
- With the macro: three extra outputs, zero, carry and ovf, registered alongside c and reset to 0.
  - zero = (c==0) for all ops.
  - carry = carry-out for add; borrow (a<b) for sub; 0 for all other ops.
  - ovf = signed two's-complement overflow for add/sub; 0 for all other ops.
- Without the macro: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then a=8, b=4, sel=001, in_valid=1 for 1 cycle, out_ready=1 -> out_valid=1 one cycle after accept, c=12, then out_valid=0.
- a=12, b=3, sel=111 -> busy=1 for 20 cycles, in_ready=0 throughout, out_valid=1 on edge 21, c=36.
- a=4, b=8, sel=010 with ALU_SEQ_FLAGS_EN -> c=0xFFFFC, carry=1, zero=0. Then a=b=5, sel=010 -> c=0, zero=1.
- Back-pressure: sel=101, a=0x1C, b=0x48, out_ready=0 for 5 cycles -> c=0x54 held stable, in_ready=0. Raising out_ready with a new in_valid (sel=000, a=7) -> next c=7, out_valid stays 1.
- Shift edge cases: a=0x1C, b=2, sel=110 -> c=0x70. a=0x1C, b=20 -> c=0.
- rst pulsed at cycle 10 of a multiply -> c=0, out_valid=0, busy=0 immediately. No stale result after release; next add op returns its correct value.
